// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, FSM state codes and coefficient type for fir_coef_ctrl
package fir_pkg;

  localparam int unsigned NTAPS    = 11;
  localparam int unsigned NB       = 11;
  localparam int unsigned FILT_LAT = 3;
  localparam int unsigned CW       = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_SWAP  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  typedef logic signed [NB-1:0] coef_t;

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow coefficient register file with atomic parallel load into the active bank
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [CW-1:0]     i_waddr,
  input  coef_t             i_wdata,
  input  logic              i_swap,
  output coef_t [NTAPS-1:0] o_h
);

  coef_t [NTAPS-1:0] r_shadow;
  coef_t [NTAPS-1:0] r_active;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        if (i_we && (i_waddr == CW'(i))) begin
          r_shadow[i] <= i_wdata;
        end
      end
      // whole-bank copy: the filter never sees a mix of old and new taps
      if (i_swap) begin
        r_active <= r_shadow;
      end
    end
  end

  assign o_h = r_active;

endmodule

// File: rtl/fir_coef_ctrl.sv
// rtl/fir_coef_ctrl.sv - coefficient reload controller: load, drain, atomic swap, sample forwarding
// Optional delay-line flush after swap is enabled by defining FIR_COEF_CTRL_FLUSH_EN.
module fir_coef_ctrl
  import fir_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [NB-1:0] CFG_DATA,
  input  logic          CFG_LAST,
  output logic          CFG_ERR,
  output logic          BUSY,
  input  logic [NB-1:0] DIN_UP,
  input  logic          VIN_UP,
  output logic          STALL,
  output logic [NB-1:0] DIN,
  output logic          VIN,
  input  logic          VOUT_F,
  output logic [NB-1:0] H0,
  output logic [NB-1:0] H1,
  output logic [NB-1:0] H2,
  output logic [NB-1:0] H3,
  output logic [NB-1:0] H4,
  output logic [NB-1:0] H5,
  output logic [NB-1:0] H6,
  output logic [NB-1:0] H7,
  output logic [NB-1:0] H8,
  output logic [NB-1:0] H9,
  output logic [NB-1:0] H10
);

  logic [2:0]        r_state;
  logic [CW-1:0]     r_wcnt;
  logic [CW-1:0]     r_dcnt;
  logic              r_err;
  logic              r_stall;
  logic              r_vin;
  logic [NB-1:0]     r_din;

  logic              w_in_cfg;
  logic              w_acc;
  logic              w_at_end;
  logic              w_err;
  logic              w_done;
  logic              w_swap;
  coef_t [NTAPS-1:0] w_h;

  assign w_in_cfg = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign w_acc    = CFG_VALID && w_in_cfg;
  assign w_at_end = (r_wcnt == CW'(NTAPS - 1));
  // LAST must coincide exactly with the final tap; anything else rejects the set
  assign w_err    = w_acc && (CFG_LAST != w_at_end);
  assign w_done   = w_acc && CFG_LAST && w_at_end;
  assign w_swap   = (r_state == S_SWAP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
      r_vin   <= 1'b0;
      r_din   <= '0;
    end else begin
      r_err   <= w_err;
      r_stall <= !w_in_cfg;

`ifdef FIR_COEF_CTRL_FLUSH_EN
      if (r_state == S_FLUSH) begin
        r_vin <= 1'b1;
        r_din <= '0;
      end else
`endif
      if (!r_stall) begin
        r_vin <= VIN_UP;
        r_din <= DIN_UP;
      end else begin
        r_vin <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_acc) begin
            if (w_err) begin
              r_state <= S_IDLE;
              r_wcnt  <= '0;
            end else if (w_done) begin
              r_state <= S_DRAIN;
              r_wcnt  <= '0;
              r_dcnt  <= '0;
            end else begin
              r_state <= S_LOAD;
              r_wcnt  <= r_wcnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (VOUT_F) begin
            r_dcnt <= '0;
          end else if (r_dcnt == CW'(FILT_LAT - 1)) begin
            r_state <= S_SWAP;
            r_dcnt  <= '0;
          end else begin
            r_dcnt <= r_dcnt + CW'(1);
          end
        end
        S_SWAP: begin
`ifdef FIR_COEF_CTRL_FLUSH_EN
          r_state <= S_FLUSH;
`else
          r_state <= S_IDLE;
`endif
          r_dcnt  <= '0;
        end
`ifdef FIR_COEF_CTRL_FLUSH_EN
        S_FLUSH: begin
          if (r_dcnt == CW'(NTAPS - 1)) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
          end else begin
            r_dcnt <= r_dcnt + CW'(1);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fir_coef_bank u_bank (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_we    (w_acc),
    .i_waddr (r_wcnt),
    .i_wdata (CFG_DATA),
    .i_swap  (w_swap),
    .o_h     (w_h)
  );

  assign CFG_READY = w_in_cfg;
  assign BUSY      = !w_in_cfg;
  assign CFG_ERR   = r_err;
  assign STALL     = r_stall;
  assign DIN       = r_din;
  assign VIN       = r_vin;

  assign H0  = w_h[0];
  assign H1  = w_h[1];
  assign H2  = w_h[2];
  assign H3  = w_h[3];
  assign H4  = w_h[4];
  assign H5  = w_h[5];
  assign H6  = w_h[6];
  assign H7  = w_h[7];
  assign H8  = w_h[8];
  assign H9  = w_h[9];
  assign H10 = w_h[10];

endmodule
